// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the RV32I execute stage to a grant/rvalid data-memory port.
// One access in flight; byte-lane steering on stores, lane extraction plus extension on loads.

package lsu_pkg;
   typedef enum logic [3:0] {
      L_B  = 4'd0,
      L_BU = 4'd1,
      L_H  = 4'd2,
      L_HU = 4'd3,
      L_W  = 4'd4,
      S_B  = 4'd5,
      S_H  = 4'd6,
      S_W  = 4'd7
   } load_store_type_e;
endpackage

module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  load_store_type_e     req_type_i,
   input  logic [ADDR_W-1:0]    req_addr_i,
   input  logic [XLEN-1:0]      req_wdata_i,
   output logic                 rsp_valid_o,
   output logic [XLEN-1:0]      rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [XLEN-1:0]      mem_wdata_o,
   output logic [XLEN/8-1:0]    mem_strb_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [XLEN-1:0]      mem_rdata_i,
   input  logic                 mem_err_i
);

   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

   state_e                state_q, state_d;
   load_store_type_e      type_q, type_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [XLEN-1:0]       rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  reqMisaligned;
   logic                  isStore;
   logic [OFF_W-1:0]      laneOff;
   logic [OFF_W+2:0]      laneShamt;
   logic [STRB_W-1:0]     laneStrb;
   logic [XLEN-1:0]       byteMask;
   logic [31:0]           laneRdata;
   logic [XLEN-1:0]       loadExt;
   logic                  timeoutHit;

   // Alignment is judged on the raw request; unknown encodings are refused the same way.
   always_comb begin
      reqMisaligned = 1'b1;
      case (req_type_i)
         L_B, L_BU, S_B: reqMisaligned = 1'b0;
         L_H, L_HU, S_H: reqMisaligned = req_addr_i[0];
         L_W, S_W:       reqMisaligned = |req_addr_i[1:0];
         default:        reqMisaligned = 1'b1;
      endcase
   end

   assign isStore   = (type_q == S_B) || (type_q == S_H) || (type_q == S_W);
   assign laneOff   = addr_q[OFF_W-1:0];
   assign laneShamt = {laneOff, 3'b000};

   always_comb begin
      laneStrb = '0;
      case (type_q)
         S_B:     laneStrb = STRB_W'(1)     << laneOff;
         S_H:     laneStrb = STRB_W'(3)     << laneOff;
         S_W:     laneStrb = STRB_W'(4'hF)  << laneOff;
         default: laneStrb = '0;
      endcase
   end

   always_comb begin
      byteMask = '0;
      for (int b = 0; b < STRB_W; b++) begin
         byteMask[8*b +: 8] = {8{laneStrb[b]}};
      end
   end

   // Shifting the read word down puts the addressed lane at bit 0 for every access size.
   assign laneRdata = 32'(mem_rdata_i >> laneShamt);

   always_comb begin
      loadExt = '0;
      case (type_q)
         L_B:     loadExt = XLEN'(signed'(laneRdata[7:0]));
         L_BU:    loadExt = XLEN'(laneRdata[7:0]);
         L_H:     loadExt = XLEN'(signed'(laneRdata[15:0]));
         L_HU:    loadExt = XLEN'(laneRdata[15:0]);
         L_W:     loadExt = XLEN'(signed'(laneRdata[31:0]));
         default: loadExt = '0;
      endcase
   end

   assign timeoutHit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         type_q  <= L_B;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // The timeout check sits on the last permitted cycle so mem_req_o never outlives the budget.
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               type_d  = req_type_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               rdata_d = '0;
               cnt_d   = '0;
               err_d   = reqMisaligned;
               state_d = reqMisaligned ? RESP : REQ;
            end
         end
         REQ: begin
            if (mem_gnt_i) begin
               cnt_d = '0;
               if (mem_rvalid_i) begin
                  err_d   = mem_err_i;
                  rdata_d = (mem_err_i || isStore) ? '0 : loadExt;
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
               end
            end else if (timeoutHit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               err_d   = mem_err_i;
               rdata_d = (mem_err_i || isStore) ? '0 : loadExt;
               state_d = RESP;
            end else if (timeoutHit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
   assign rsp_err_o   = (state_q == RESP) && err_q;

   assign mem_req_o   = (state_q == REQ);
   assign mem_we_o    = (state_q == REQ) && isStore;
   assign mem_addr_o  = (state_q == REQ) ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
   assign mem_strb_o  = (state_q == REQ) ? laneStrb : '0;
   assign mem_wdata_o = (state_q == REQ) ? ((wdata_q << laneShamt) & byteMask) : '0;

endmodule
